// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: producer side (program counter) and consumer side (decode),
// plus predecoded head fields.
interface fetch_buffer_if #(
  parameter int unsigned PC_WIDTH = 30
);
  logic [31:0]         inst_in;
  logic [PC_WIDTH-1:0] pc_in;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic                out_ready;
  logic                out_valid;
  logic [31:0]         inst_out;
  logic [PC_WIDTH-1:0] pc_out;
  logic [5:0]          opcode;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [5:0]          funct;
  logic [31:0]         se_imm;
  logic [25:0]         target;
  logic                jump;
  logic                branch;
  logic [1:0]          count;

  modport slave (
    input  inst_in, pc_in, in_valid, flush, out_ready,
    output in_ready, out_valid, inst_out, pc_out, opcode, rs, rt, rd, funct,
           se_imm, target, jump, branch, count
  );

  modport master (
    output inst_in, pc_in, in_valid, flush, out_ready,
    input  in_ready, out_valid, inst_out, pc_out, opcode, rs, rt, rd, funct,
           se_imm, target, jump, branch, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction fetch FIFO with head-entry predecode and synchronous flush.
// in_ready depends only on registered occupancy, so the stall path never sees out_ready.
module fetch_buffer #(
  parameter int unsigned PC_WIDTH = 30
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.slave  bus
);

  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic [31:0]         inst_q [2];
  logic [PC_WIDTH-1:0] pc_q   [2];

  logic                in_ready, out_valid, push, pop;
  logic [31:0]         head_inst;
  logic [PC_WIDTH-1:0] head_pc;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  // Flush wins over both sides of the handshake.
  assign push      = bus.in_valid & in_ready & ~bus.flush;
  assign pop       = out_valid & bus.out_ready & ~bus.flush;

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (bus.flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q         <= ~wr_ptr_q;
          inst_q[wr_ptr_q] <= bus.inst_in;
          pc_q[wr_ptr_q]   <= bus.pc_in;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // Stale storage is masked so an empty buffer presents all-zero fields.
  assign head_inst = out_valid ? inst_q[rd_ptr_q] : '0;
  assign head_pc   = out_valid ? pc_q[rd_ptr_q]   : '0;

  always_comb begin
    bus.jump   = 1'b0;
    bus.branch = 1'b0;
    case (head_inst[31:26])
      6'b000010: bus.jump = 1'b1;
      6'b000001: bus.branch = (head_inst[20:16] == 5'b00000);
      6'b000000: begin
        if (head_inst[5:0] == 6'b001000) begin
          bus.jump   = 1'b1;
          bus.branch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.inst_out  = head_inst;
  assign bus.pc_out    = head_pc;
  assign bus.opcode    = head_inst[31:26];
  assign bus.rs        = head_inst[25:21];
  assign bus.rt        = head_inst[20:16];
  assign bus.rd        = head_inst[15:11];
  assign bus.funct     = head_inst[5:0];
  assign bus.se_imm    = {{16{head_inst[15]}}, head_inst[15:0]};
  assign bus.target    = head_inst[25:0];

endmodule
